ifetch_queue: RTL and testbench

Instruction-fetch buffer directly downstream of the program-counter stage of the RV32I core.
- Takes the current PC and issues instruction-memory requests. Drives the PC stage's advance enable on every accepted request.
- Pairs in-order memory responses with their PCs and presents {pc, instr} to decode over a valid/ready handshake.
- Supports pipeline flush and discards stale in-flight responses.

---
 rtl/ifetch_queue.sv | 200 ++++++++++++++++++++
 tb/tb_ifetch_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Instruction-fetch buffer sitting between the PC stage and decode of the
//   RV32I core. It issues instruction-memory requests for the current PC,
//   tells the PC stage to advance whenever a request is granted, pairs the
//   in-order memory responses with their PCs and hands {pc, instr} to decode
//   over a valid/ready handshake. A flush drops everything buffered and
//   silently swallows the responses of fetches that were still in flight.
//
// Parameters
//   DEPTH        number of buffer slots (power of 2, >= 2); also the cap on
//                occupied plus outstanding entries.
//
// Ports
//   clk          clock, rising edge
//   res          asynchronous active-low reset
//   pc_i         current PC from the PC stage
//   pc_en        PC advance enable, high exactly when imem_req && imem_gnt
//   imem_req     instruction-memory request valid
//   imem_addr    word-aligned request address
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  response valid (in request order, >= 1 cycle after grant)
//   imem_rdata   response instruction word
//   flush        redirect: discard buffer contents and in-flight fetches
//   id_valid     head entry available to decode
//   id_pc        PC of head entry (0 while nothing is presented)
//   id_instr     instruction of head entry (0 while nothing is presented)
//   id_ready     decode consumes the head entry when id_valid && id_ready
//
// Build option
//   IFQ_BYPASS_EN  when defined, a response arriving while the buffer holds
//                  no filled entry is forwarded combinationally to decode in
//                  the same cycle. Undefined (default): no combinational
//                  path from imem_* to id_*.
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] pc_i,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    input  logic        id_ready
);

    // Slot index width and pointer width (one extra wrap bit so that
    // "full" and "empty" are distinguishable).
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);

    // Slot storage
    logic [31:0]   pc_q_r    [DEPTH];
    logic [31:0]   instr_q_r [DEPTH];

    // alloc: next slot to receive a granted PC
    // fill : next slot to receive a response word
    // rd   : head slot presented to decode
    logic [PW-1:0] alloc_ptr_r;
    logic [PW-1:0] fill_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    // Number of in-flight responses still to be thrown away after a flush
    logic [PW-1:0] discard_r;

    logic [PW-1:0] occ_s;
    logic [PW-1:0] outstanding_s;
    logic          discard_idle_s;
    logic          grant_s;
    logic          drop_s;
    logic          rsp_fill_s;
    logic          have_entry_s;
    logic          pop_s;
    logic [PW-1:0] discard_flush_s;
    logic [AW-1:0] rd_idx_s;
    logic [AW-1:0] alloc_idx_s;
    logic [AW-1:0] fill_idx_s;
`ifdef IFQ_BYPASS_EN
    logic          bypass_s;
`endif

    assign rd_idx_s    = rd_ptr_r[AW-1:0];
    assign alloc_idx_s = alloc_ptr_r[AW-1:0];
    assign fill_idx_s  = fill_ptr_r[AW-1:0];

    // Request / grant / response qualification, all from registered state
    // so that a pop in a full cycle cannot open a request in that cycle.
    always_comb begin
        occ_s          = alloc_ptr_r - rd_ptr_r;
        outstanding_s  = alloc_ptr_r - fill_ptr_r;
        discard_idle_s = (discard_r == PTR_ZERO);

        imem_req  = res && !flush && discard_idle_s && (occ_s < DEPTH_P);
        imem_addr = {pc_i[31:2], 2'b00};

        grant_s = imem_req && imem_gnt;
        pc_en   = grant_s;

        // A stale response is dropped while discard is non-zero. A response
        // with nothing outstanding is a protocol error and is ignored.
        drop_s     = imem_rvalid && !discard_idle_s;
        rsp_fill_s = imem_rvalid && discard_idle_s && (outstanding_s != PTR_ZERO);

        // Discard count loaded on flush: everything still in flight that is
        // not consumed by a response landing in the flush cycle itself.
        discard_flush_s = outstanding_s - PW'(rsp_fill_s)
                        + discard_r     - PW'(drop_s);
    end

    // Decode-side view: head slot when filled, optional same-cycle forward
    // of an arriving response, zeros otherwise.
    always_comb begin
        have_entry_s = (fill_ptr_r != rd_ptr_r);
        id_valid     = 1'b0;
        id_pc        = 32'h0000_0000;
        id_instr     = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
        bypass_s = !have_entry_s && rsp_fill_s && !flush;
        if (have_entry_s) begin
            id_valid = 1'b1;
            id_pc    = pc_q_r[rd_idx_s];
            id_instr = instr_q_r[rd_idx_s];
        end else if (bypass_s) begin
            // fill slot == head slot here; its PC was captured at grant
            id_valid = 1'b1;
            id_pc    = pc_q_r[rd_idx_s];
            id_instr = imem_rdata;
        end else begin
            id_valid = 1'b0;
            id_pc    = 32'h0000_0000;
            id_instr = 32'h0000_0000;
        end
`else
        if (have_entry_s) begin
            id_valid = 1'b1;
            id_pc    = pc_q_r[rd_idx_s];
            id_instr = instr_q_r[rd_idx_s];
        end else begin
            id_valid = 1'b0;
            id_pc    = 32'h0000_0000;
            id_instr = 32'h0000_0000;
        end
`endif
        // Flush blocks consumption even though id_valid may read high.
        pop_s = id_valid && id_ready && !flush;
    end

    // Pointer and discard-counter update; flush collapses the buffer onto
    // the current fill pointer, otherwise each pointer advances on its own.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            alloc_ptr_r <= PTR_ZERO;
            fill_ptr_r  <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            discard_r   <= PTR_ZERO;
        end else if (flush) begin
            alloc_ptr_r <= fill_ptr_r;
            fill_ptr_r  <= fill_ptr_r;
            rd_ptr_r    <= fill_ptr_r;
            discard_r   <= discard_flush_s;
        end else begin
            alloc_ptr_r <= alloc_ptr_r + PW'(grant_s);
            fill_ptr_r  <= fill_ptr_r + PW'(rsp_fill_s);
            rd_ptr_r    <= rd_ptr_r + PW'(pop_s);
            discard_r   <= discard_r - PW'(drop_s);
        end
    end

    // Slot storage: PC captured at grant, instruction captured at response.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q_r[i]    <= 32'h0000_0000;
                instr_q_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (grant_s) begin
                pc_q_r[alloc_idx_s] <= pc_i;
            end else begin
                pc_q_r[alloc_idx_s] <= pc_q_r[alloc_idx_s];
            end
            if (rsp_fill_s && !flush) begin
                instr_q_r[fill_idx_s] <= imem_rdata;
            end else begin
                instr_q_r[fill_idx_s] <= instr_q_r[fill_idx_s];
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue
//   Self-checking bench for ifetch_queue (DEPTH = 4). A small memory model
//   answers granted fetches in order; every response that should survive is
//   pushed onto an expected queue and compared when decode pops it.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] pc_i;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

`ifdef IFQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [31:0] pc;
        bit          stale;
        int          gcyc;
    } ent_t;

    ent_t pend_q[$];   // granted, response not yet returned
    ent_t exp_q[$];    // returned, waiting for decode to pop

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int gcnt     = 0;
    int pcnt     = 0;
    bit adv      = 1'b0;
    bit rsp_en   = 1'b0;
    bit lat_chk  = 1'b0;

    ifetch_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .res         (res),
        .pc_i        (pc_i),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard bookkeeping for the current cycle, sampled at the falling edge.
    task automatic account();
        ent_t e;
        cyc++;
        if (imem_rvalid && pend_q.size() > 0) begin
            e = pend_q.pop_front();
            if (!e.stale && !flush) exp_q.push_back(e);
        end
        if (id_valid && id_ready && !flush) begin
            pcnt++;
            if (exp_q.size() == 0) begin
                check_eq("pop_unexpected", 32'(id_pc), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("id_pc", id_pc, e.pc);
                check_eq("id_instr", id_instr, instr_of(e.pc));
                if (lat_chk) check_eq("latency", 32'(cyc - e.gcyc), 32'(LAT));
            end
        end
        check_eq("pc_en", {31'd0, pc_en}, {31'd0, imem_req && imem_gnt});
        adv = 1'b0;
        if (imem_req && imem_gnt) begin
            check_eq("imem_addr", imem_addr, {pc_i[31:2], 2'b00});
            e.pc = pc_i; e.stale = 1'b0; e.gcyc = cyc;
            pend_q.push_back(e);
            gcnt++;
            adv = 1'b1;
        end
        if (flush) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            exp_q.delete();
        end
    endtask

    // One clock: account at negedge, then update PC model and memory at posedge+1.
    task automatic tick();
        @(negedge clk);
        account();
        @(posedge clk);
        #1;
        if (adv) pc_i = pc_i + 32'd4;
        if (rsp_en && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend_q[0].pc);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        res = 1'b0; flush = 1'b0; imem_gnt = 1'b0; id_ready = 1'b0;
        imem_rvalid = 1'b0; rsp_en = 1'b0; lat_chk = 1'b0;
        pend_q.delete(); exp_q.delete();
        tick(); tick();
        res = 1'b1;
    endtask

    task automatic drain();
        imem_gnt = 1'b0; id_ready = 1'b1; rsp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && pend_q.size() == 0) break;
            tick();
        end
        check_eq("drain_left", 32'(exp_q.size() + pend_q.size()), 32'd0);
        #1;
        check_eq("drain_id_valid", {31'd0, id_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int p0;
        res = 1'b0; pc_i = 32'h0; imem_gnt = 1'b1; imem_rvalid = 1'b0;
        imem_rdata = 32'h0; flush = 1'b0; id_ready = 1'b0;

        // Reset held 3 cycles with grant asserted
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_eq("rst_req", {31'd0, imem_req}, 32'd0);
            check_eq("rst_pc_en", {31'd0, pc_en}, 32'd0);
            check_eq("rst_id_valid", {31'd0, id_valid}, 32'd0);
            check_eq("rst_id_pc", id_pc, 32'h0);
        end

        // Release and stream
        res = 1'b1; id_ready = 1'b1; rsp_en = 1'b1; lat_chk = 1'b1; pc_i = 32'h0;
        #1;
        check_eq("rel_req", {31'd0, imem_req}, 32'd1);
        check_eq("rel_addr", imem_addr, 32'h0);
        p0 = pcnt;
        tick(); tick(); tick();
        imem_gnt = 1'b0;
        tick(); tick(); tick();
        check_eq("stream_pops", 32'(pcnt - p0), 32'd3);
        lat_chk = 1'b0;
        drain();

        // Backpressure: fill to DEPTH, one pop admits exactly one grant
        do_reset();
        pc_i = 32'h0; imem_gnt = 1'b1; id_ready = 1'b0; rsp_en = 1'b1;
        g0 = gcnt;
        for (int i = 0; i < 8; i++) tick();
        #1;
        check_eq("bp_grants", 32'(gcnt - g0), 32'd4);
        check_eq("bp_req", {31'd0, imem_req}, 32'd0);
        check_eq("bp_pc_en", {31'd0, pc_en}, 32'd0);
        check_eq("bp_pc_model", pc_i, 32'h10);
        check_eq("bp_head_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        #1;
        check_eq("bp_req_popcycle", {31'd0, imem_req}, 32'd0);
        tick();
        id_ready = 1'b0;
        #1;
        check_eq("bp_req_after_pop", {31'd0, imem_req}, 32'd1);
        check_eq("bp_addr_after_pop", imem_addr, 32'h10);
        tick(); tick(); tick();
        check_eq("bp_grants2", 32'(gcnt - g0), 32'd5);
        check_eq("bp_req_full2", {31'd0, imem_req}, 32'd0);
        drain();

        // Flush with two fetches in flight
        do_reset();
        pc_i = 32'h20; imem_gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b0;
        tick(); tick();
        imem_gnt = 1'b0; flush = 1'b1; rsp_en = 1'b1;
        #1;
        check_eq("fl_req_in_flush", {31'd0, imem_req}, 32'd0);
        tick();
        flush = 1'b0; pc_i = 32'h100;
        #1;
        check_eq("fl_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("fl_req_drop1", {31'd0, imem_req}, 32'd0);
        tick();
        #1;
        check_eq("fl_req_drop2", {31'd0, imem_req}, 32'd0);
        tick();
        #1;
        check_eq("fl_req_resume", {31'd0, imem_req}, 32'd1);
        check_eq("fl_addr_resume", imem_addr, 32'h100);
        p0 = pcnt;
        imem_gnt = 1'b1;
        tick();
        drain();
        check_eq("fl_pops", 32'(pcnt - p0), 32'd1);

        // Async reset between edges with three entries buffered
        do_reset();
        pc_i = 32'h200; imem_gnt = 1'b1; id_ready = 1'b0; rsp_en = 1'b1;
        tick(); tick(); tick();
        imem_gnt = 1'b0;
        tick(); tick();
        #1;
        check_eq("ar_pre_valid", {31'd0, id_valid}, 32'd1);
        res = 1'b0; imem_rvalid = 1'b0;
        #1;
        check_eq("ar_id_valid", {31'd0, id_valid}, 32'd0);
        check_eq("ar_req", {31'd0, imem_req}, 32'd0);
        pend_q.delete(); exp_q.delete();
        tick(); tick();
        res = 1'b1; pc_i = 32'h300; imem_gnt = 1'b1; id_ready = 1'b1;
        #1;
        check_eq("ar_rel_req", {31'd0, imem_req}, 32'd1);
        check_eq("ar_rel_addr", imem_addr, 32'h300);
        check_eq("ar_rel_valid", {31'd0, id_valid}, 32'd0);
        p0 = pcnt;
        tick(); tick();
        drain();
        check_eq("ar_pops", 32'(pcnt - p0), 32'd2);

        // Single fetch into empty buffer: same-cycle forward only with bypass
        do_reset();
        pc_i = 32'h40; imem_gnt = 1'b1; id_ready = 1'b1; rsp_en = 1'b1;
        #1;
        check_eq("bx_req", {31'd0, imem_req}, 32'd1);
        tick();
        imem_gnt = 1'b0;
        #1;
`ifdef IFQ_BYPASS_EN
        check_eq("bx_valid_t1", {31'd0, id_valid}, 32'd1);
        check_eq("bx_pc_t1", id_pc, 32'h40);
        check_eq("bx_instr_t1", id_instr, instr_of(32'h40));
        tick();
        #1;
        check_eq("bx_valid_t2", {31'd0, id_valid}, 32'd0);
`else
        check_eq("bx_valid_t1", {31'd0, id_valid}, 32'd0);
        tick();
        #1;
        check_eq("bx_valid_t2", {31'd0, id_valid}, 32'd1);
        check_eq("bx_pc_t2", id_pc, 32'h40);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
